// File: rtl/ft245_device_responder.sv
// ---------------------------------------------------------------------------
// ft245_device_responder
//
// Chip-side model of an FT245-style asynchronous FIFO link. It plays the
// part of the USB chip: bytes arriving on a host-side stream are offered to
// the FPGA through rxf/rdn, and bytes the FPGA writes through txe/wrn are
// handed back out on a host-side stream. Useful for loopback, self-test and
// as a synthesizable partner for the FPGA-side USB interface.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   bus   [7:0]   FT245 data bus, driven here only while serving a read
//   rxf           active-low "RX byte available" flag towards the FPGA
//   txe           active-low "TX space available" flag towards the FPGA
//   rdn, wrn      active-low read/write strobes from the FPGA (asynchronous)
//   h_rxd/h_rxv/h_rxr   host -> FPGA byte stream (valid/ready)
//   h_txd/h_txv/h_txr   FPGA -> host byte stream (valid/ready, FWFT)
//   err           one-cycle pulse on any strobe protocol violation
// ---------------------------------------------------------------------------
module ft245_device_responder #(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter int PRE_CYC  = 4
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] bus,
  output logic       rxf,
  output logic       txe,
  input  logic       rdn,
  input  logic       wrn,
  input  logic [7:0] h_rxd,
  input  logic       h_rxv,
  output logic       h_rxr,
  output logic [7:0] h_txd,
  output logic       h_txv,
  input  logic       h_txr,
  output logic       err
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int PRE_W = (PRE_CYC > 1) ? $clog2(PRE_CYC) : 1;
  localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(PRE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RPRE,
    ST_WPRE
  } state_t;

  // Strobe synchronizers: [0] first stage, [1] second stage, [2] previous
  // synchronized value used for edge detection. Idle level is 1.
  logic [2:0] rdn_sync_q, rdn_sync_d;
  logic [2:0] wrn_sync_q, wrn_sync_d;
  logic [7:0] bus_s1_q, bus_s1_d;
  logic [7:0] bus_s2_q, bus_s2_d;

  logic rdn_fall, rdn_rise, wrn_fall, wrn_rise;

  // FIFO pointers carry one extra wrap bit so full and empty can be told apart.
  logic [RX_AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [TX_AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [7:0]     rx_mem_d [RX_DEPTH];
  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [7:0]     tx_mem_d [TX_DEPTH];

  logic       rx_empty, rx_full, tx_empty, tx_full;
  logic       rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0] rx_head;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             rxf_q, rxf_d;
  logic             txe_q, txe_d;
  logic             bus_oe_q, bus_oe_d;
  logic [7:0]       bus_out_q, bus_out_d;
  logic             err_q, err_d;

  // Edge detection runs on the second synchronizer stage against its own
  // previous value, so every strobe edge produces exactly one event.
  assign rdn_fall = rdn_sync_q[2] & ~rdn_sync_q[1];
  assign rdn_rise = ~rdn_sync_q[2] & rdn_sync_q[1];
  assign wrn_fall = wrn_sync_q[2] & ~wrn_sync_q[1];
  assign wrn_rise = ~wrn_sync_q[2] & wrn_sync_q[1];

  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                    (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                    (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);

  assign rx_head = rx_mem_q[rx_rd_q[RX_AW-1:0]];

  // Host-side handshakes. h_rxr is forced low while reset is held.
  assign h_rxr   = ~rx_full & ~rst;
  assign rx_push = h_rxv & h_rxr;
  assign h_txv   = ~tx_empty;
  assign h_txd   = tx_mem_q[tx_rd_q[TX_AW-1:0]];
  assign tx_pop  = h_txv & h_txr;

  // FPGA-side FIFO accesses happen only on the strobe release inside the
  // matching transfer state; space/data was guaranteed when it was entered.
  assign rx_pop  = (state_q == ST_READ) & rdn_rise;
  assign tx_push = (state_q == ST_WRITE) & wrn_rise;

  // Next values for the synchronizers and FIFO pointers.
  always_comb begin
    rdn_sync_d = {rdn_sync_q[1:0], rdn};
    wrn_sync_d = {wrn_sync_q[1:0], wrn};
    bus_s1_d   = bus;
    bus_s2_d   = bus_s1_q;
    rx_wr_d    = rx_wr_q;
    rx_rd_d    = rx_rd_q;
    tx_wr_d    = tx_wr_q;
    tx_rd_d    = tx_rd_q;
    if (rx_push) rx_wr_d = rx_wr_q + {{RX_AW{1'b0}}, 1'b1};
    if (rx_pop)  rx_rd_d = rx_rd_q + {{RX_AW{1'b0}}, 1'b1};
    if (tx_push) tx_wr_d = tx_wr_q + {{TX_AW{1'b0}}, 1'b1};
    if (tx_pop)  tx_rd_d = tx_rd_q + {{TX_AW{1'b0}}, 1'b1};
  end

  // FIFO storage updates. The write slot is never the slot being read
  // except at full, where the old head is consumed before it is replaced.
  always_comb begin
    rx_mem_d = rx_mem_q;
    tx_mem_d = tx_mem_q;
    if (rx_push) rx_mem_d[rx_wr_q[RX_AW-1:0]] = h_rxd;
    if (tx_push) tx_mem_d[tx_wr_q[TX_AW-1:0]] = bus_s2_q;
  end

  // Storage needs no reset: emptiness is defined purely by the pointers.
  always_ff @(posedge clk) begin
    rx_mem_q <= rx_mem_d;
    tx_mem_q <= tx_mem_d;
  end

  // Synchronizer and pointer registers. Reset empties both FIFOs and parks
  // the strobe synchronizers at their inactive level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdn_sync_q <= 3'b111;
      wrn_sync_q <= 3'b111;
      bus_s1_q   <= 8'h00;
      bus_s2_q   <= 8'h00;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
    end else begin
      rdn_sync_q <= rdn_sync_d;
      wrn_sync_q <= wrn_sync_d;
      bus_s1_q   <= bus_s1_d;
      bus_s2_q   <= bus_s2_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
    end
  end

  // Protocol FSM next-state logic. Flag outputs are computed from the next
  // state so that they are registered together with it. In IDLE the flags
  // the FPGA currently sees are trusted: only the FPGA can drain RX or fill
  // TX, so a low flag can never go stale while idle.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    err_d     = 1'b0;
    bus_oe_d  = 1'b0;
    bus_out_d = bus_out_q;
    rxf_d     = 1'b1;
    txe_d     = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (rdn_fall && wrn_fall) begin
          err_d = 1'b1;
          if (!rxf_q) state_d = ST_READ;
        end else if (rdn_fall) begin
          if (!rxf_q) state_d = ST_READ;
          else        err_d   = 1'b1;
        end else if (wrn_fall) begin
          if (!txe_q) state_d = ST_WRITE;
          else        err_d   = 1'b1;
        end
      end
      ST_READ: begin
        // Head cannot change while reading, so the bus value is stable.
        bus_oe_d  = ~rdn_rise;
        bus_out_d = rx_head;
        if (wrn_fall) err_d = 1'b1;
        if (rdn_rise) begin
          state_d = ST_RPRE;
          pre_d   = PRE_LOAD;
        end
      end
      ST_WRITE: begin
        if (rdn_fall) err_d = 1'b1;
        if (wrn_rise) begin
          state_d = ST_WPRE;
          pre_d   = PRE_LOAD;
        end
      end
      ST_RPRE, ST_WPRE: begin
        if (rdn_fall || rdn_rise || wrn_fall || wrn_rise) err_d = 1'b1;
        if (pre_q == '0) state_d = ST_IDLE;
        else             pre_d   = pre_q - PRE_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    unique case (state_d)
      ST_IDLE: begin
        rxf_d = rx_empty;
        txe_d = tx_full;
      end
      ST_READ: begin
        rxf_d = 1'b0;
        txe_d = 1'b1;
      end
      ST_WRITE: begin
        rxf_d = 1'b1;
        txe_d = 1'b0;
      end
      default: begin
        rxf_d = 1'b1;
        txe_d = 1'b1;
      end
    endcase
  end

  // FSM state and registered outputs; reset abandons any transfer at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      rxf_q     <= 1'b1;
      txe_q     <= 1'b1;
      bus_oe_q  <= 1'b0;
      bus_out_q <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      rxf_q     <= rxf_d;
      txe_q     <= txe_d;
      bus_oe_q  <= bus_oe_d;
      bus_out_q <= bus_out_d;
      err_q     <= err_d;
    end
  end

  assign rxf = rxf_q;
  assign txe = txe_q;
  assign err = err_q;
  assign bus = bus_oe_q ? bus_out_q : 8'bz;

endmodule

// File: tb/tb_ft245_device_responder.sv
// ---------------------------------------------------------------------------
// tb_ft245_device_responder
//
// Scoreboard bench for ft245_device_responder. Stimulus pushes the bytes it
// expects to see into queues; independent monitors pop and compare whenever
// the DUT presents a byte on the bus (during a read) or on h_txd (during a
// host handshake). Directed checks cover flags, precharge, errors and reset.
// ---------------------------------------------------------------------------
module tb_ft245_device_responder;

  localparam int PRE_CYC = 4;
  localparam int FLAG_CAP = 12;

  logic       clk = 1'b0;
  logic       rst;
  wire  [7:0] bus;
  logic [7:0] tb_bus_d;
  logic       tb_bus_oe;
  logic       rxf, txe, rdn, wrn;
  logic [7:0] h_rxd;
  logic       h_rxv, h_rxr;
  logic [7:0] h_txd;
  logic       h_txv, h_txr;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;

  logic [7:0] rx_exp_q [$];
  logic [7:0] tx_exp_q [$];

  assign bus = tb_bus_oe ? tb_bus_d : 8'bz;

  ft245_device_responder #(
    .RX_DEPTH(16),
    .TX_DEPTH(16),
    .PRE_CYC (PRE_CYC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .rxf  (rxf),
    .txe  (txe),
    .rdn  (rdn),
    .wrn  (wrn),
    .h_rxd(h_rxd),
    .h_rxv(h_rxv),
    .h_rxr(h_rxr),
    .h_txd(h_txd),
    .h_txv(h_txv),
    .h_txr(h_txr),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host offers one byte for a single cycle; exp_acc says whether the bench
  // expects the RX FIFO to have room for it.
  task automatic hostPush(input logic [7:0] d, input logic exp_acc);
    checkOutput("h_rxr_before_push", {31'd0, h_rxr}, {31'd0, exp_acc});
    h_rxd = d;
    h_rxv = 1'b1;
    tick();
    h_rxv = 1'b0;
    if (exp_acc) rx_exp_q.push_back(d);
  endtask

  // Counts how long a flag stays high once it rises after a strobe release.
  task automatic measureFlag(input bit use_txe, input int exp_high, input string name);
    int waited = 0;
    int n = 0;
    while (((use_txe ? txe : rxf) == 1'b0) && waited < 20) begin
      tick();
      waited++;
    end
    while (((use_txe ? txe : rxf) == 1'b1) && n < FLAG_CAP) begin
      n++;
      tick();
    end
    checkOutput(name, n, exp_high);
  endtask

  task automatic fpgaRead(input int exp_high);
    rdn = 1'b0;
    repeat (8) tick();
    rdn = 1'b1;
    measureFlag(1'b0, exp_high, "rxf_precharge");
  endtask

  task automatic fpgaWrite(input logic [7:0] d, input logic exp_push, input int exp_high);
    tb_bus_d  = d;
    tb_bus_oe = 1'b1;
    wrn       = 1'b0;
    repeat (8) tick();
    wrn = 1'b1;
    if (exp_push) tx_exp_q.push_back(d);
    measureFlag(1'b1, exp_high, "txe_precharge");
    tb_bus_oe = 1'b0;
  endtask

  task automatic applyStimulus();
    int e0;
    int rdy_cnt;

    // Reset values
    rst = 1'b1; rdn = 1'b1; wrn = 1'b1; h_rxv = 1'b0; h_rxd = 8'h00;
    h_txr = 1'b0; tb_bus_oe = 1'b0; tb_bus_d = 8'h00;
    #2;
    checkOutput("reset_rxf", {31'd0, rxf}, 32'd1);
    checkOutput("reset_txe", {31'd0, txe}, 32'd1);
    checkOutput("reset_h_rxr", {31'd0, h_rxr}, 32'd0);
    checkOutput("reset_h_txv", {31'd0, h_txv}, 32'd0);
    checkOutput("reset_err", {31'd0, err}, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    checkOutput("idle_rxf", {31'd0, rxf}, 32'd1);
    checkOutput("idle_txe", {31'd0, txe}, 32'd0);
    checkOutput("idle_h_rxr", {31'd0, h_rxr}, 32'd1);

    // Two host bytes, two FPGA reads
    e0 = err_cnt;
    hostPush(8'h5A, 1'b1);
    checkOutput("rxf_latency_push_cycle", {31'd0, rxf}, 32'd1);
    tick();
    checkOutput("rxf_latency_next_cycle", {31'd0, rxf}, 32'd0);
    hostPush(8'hC3, 1'b1);
    fpgaRead(PRE_CYC);
    fpgaRead(FLAG_CAP);

    // Three FPGA writes drained by the host
    h_txr = 1'b1;
    fpgaWrite(8'h11, 1'b1, PRE_CYC);
    fpgaWrite(8'h22, 1'b1, PRE_CYC);
    fpgaWrite(8'h33, 1'b1, PRE_CYC);
    checkOutput("no_err_normal_traffic", err_cnt - e0, 32'd0);

    // RX fill to 16, overflow attempt, drain with wraparound
    for (int i = 0; i < 16; i++) hostPush(8'(i), 1'b1);
    checkOutput("rx_full_h_rxr", {31'd0, h_rxr}, 32'd0);
    hostPush(8'hEE, 1'b0);
    for (int i = 0; i < 16; i++) fpgaRead((i == 15) ? FLAG_CAP : PRE_CYC);

    // TX fill to 16 with host stalled, overflow write, then drain
    h_txr = 1'b0;
    for (int i = 0; i < 16; i++)
      fpgaWrite(8'h80 + 8'(i), 1'b1, (i == 15) ? FLAG_CAP : PRE_CYC);
    checkOutput("tx_full_txe", {31'd0, txe}, 32'd1);
    e0 = err_cnt;
    fpgaWrite(8'hEE, 1'b0, FLAG_CAP);
    checkOutput("tx_overflow_err", err_cnt - e0, 32'd1);
    h_txr = 1'b1;
    begin
      int waited = 0;
      while (tx_exp_q.size() != 0 && waited < 200) begin
        tick();
        waited++;
      end
      checkOutput("tx_drain_timeout", {31'd0, waited >= 200}, 32'd0);
    end
    repeat (2) tick();
    checkOutput("tx_empty_after_drain", {31'd0, h_txv}, 32'd0);

    // Both strobes fall together with both flags low
    hostPush(8'h77, 1'b1);
    tick();
    e0 = err_cnt;
    rdn = 1'b0;
    wrn = 1'b0;
    repeat (8) tick();
    rdn = 1'b1;
    wrn = 1'b1;
    measureFlag(1'b0, FLAG_CAP, "rxf_after_dual_strobe");
    checkOutput("dual_strobe_err", err_cnt - e0, 32'd1);
    checkOutput("dual_strobe_no_tx_push", {31'd0, h_txv}, 32'd0);

    // Reset in the middle of a read
    hostPush(8'hA5, 1'b1);
    tick();
    rdn = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    checkOutput("midread_rst_rxf", {31'd0, rxf}, 32'd1);
    checkOutput("midread_rst_txe", {31'd0, txe}, 32'd1);
    checkOutput("midread_rst_h_rxr", {31'd0, h_rxr}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    rdn = 1'b1;
    repeat (6) tick();
    checkOutput("post_rst_rxf", {31'd0, rxf}, 32'd1);
    checkOutput("post_rst_h_txv", {31'd0, h_txv}, 32'd0);
    checkOutput("post_rst_h_rxr", {31'd0, h_rxr}, 32'd1);
    hostPush(8'h3C, 1'b1);
    tick();
    fpgaRead(FLAG_CAP);

    // Host push and FPGA pop around a full RX FIFO
    for (int i = 0; i < 16; i++) hostPush(8'h40 + 8'(i), 1'b1);
    h_rxd = 8'h99;
    h_rxv = 1'b1;
    rx_exp_q.push_back(8'h99);
    rdy_cnt = 0;
    fork
      fpgaRead(PRE_CYC);
      begin
        repeat (25) begin
          @(negedge clk);
          if (h_rxr) rdy_cnt++;
        end
      end
    join
    h_rxv = 1'b0;
    checkOutput("full_pop_push_rdy_cycles", rdy_cnt, 32'd1);
    checkOutput("full_again_h_rxr", {31'd0, h_rxr}, 32'd0);
    for (int i = 0; i < 16; i++) fpgaRead((i == 15) ? FLAG_CAP : PRE_CYC);
  endtask

  // Error pulse counter
  always @(negedge clk) begin
    if (err) err_cnt++;
  end

  // TX monitor: every host handshake on h_txd is compared against the queue.
  always @(negedge clk) begin
    if (!rst && h_txv && h_txr) begin
      if (tx_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL tx_unexpected: got 0x%0h, expected no byte", h_txd);
      end else begin
        checkOutput("h_txd", {24'd0, h_txd}, {24'd0, tx_exp_q.pop_front()});
      end
    end
  end

  // RX monitor: a read strobe held low with rxf low means the DUT is serving
  // a byte; it is compared once presented and again late in the strobe.
  int         rdn_low_cnt = 0;
  logic [7:0] rd_cur = 8'h00;
  logic       rd_have = 1'b0;

  always @(negedge clk) begin
    if (rdn) begin
      rdn_low_cnt = 0;
      rd_have     = 1'b0;
    end else begin
      rdn_low_cnt++;
      if (rdn_low_cnt == 5 && !rxf && !rst) begin
        if (rx_exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL rx_unexpected: got 0x%0h, expected no byte", bus);
        end else begin
          rd_cur  = rx_exp_q.pop_front();
          rd_have = 1'b1;
          checkOutput("bus_read", {24'd0, bus}, {24'd0, rd_cur});
        end
      end
      if (rdn_low_cnt == 8 && rd_have && !rxf && !rst)
        checkOutput("bus_stable", {24'd0, bus}, {24'd0, rd_cur});
    end
  end

  initial begin
    applyStimulus();
    repeat (4) tick();
    checkOutput("rx_queue_empty", rx_exp_q.size(), 32'd0);
    checkOutput("tx_queue_empty", tx_exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
